sysref_gen: RTL and testbench

- Programmable SYSREF pulse generator in the PL clock domain; the transmit-side counterpart of the PL SYSREF capture path.
- Drives a periodic or counted burst of SYSREF pulses toward RF-DAC/RF-ADC tile sync and external converters.
- Optionally phase-aligns its first pulse to a rising edge of the already-captured board SYSREF (sysref_in).
- Output is a single registered, glitch-free level suitable for an ODDR/OBUFDS wrapper at top level.

---
 rtl/sysref_gen.sv | 119 +++++++++++
 tb/tb_sysref_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sysref_gen.sv
// sysref_gen: programmable periodic / counted-burst SYSREF pulse generator with optional alignment
//   pl_clk      : PL fabric clock, all logic on rising edge
//   pl_resetn   : asynchronous active-low reset
//   cfg_period  : period P in pl_clk cycles (P >= 2)
//   cfg_high    : high time H in cycles (1 <= H <= P-1)
//   cfg_pulses  : pulse count N, 0 = continuous
//   cfg_align   : wait for a sysref_in rising edge before the first pulse
//   start/stop  : single-cycle requests (stop wins when both are set)
//   sysref_in   : captured board SYSREF, synchronous to pl_clk
//   sysref_out  : registered, glitch-free generated SYSREF
//   busy        : high in WAIT_ALIGN or RUN
//   done        : one-cycle pulse after returning to IDLE
//   cfg_err     : one-cycle pulse on start with an illegal config
//   pulse_cnt   : pulses emitted since the last accepted start, saturating
module sysref_gen #(
   parameter int CNT_W  = 16,
   parameter int PCNT_W = 8
) (
   input  logic              pl_clk,
   input  logic              pl_resetn,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic [PCNT_W-1:0] cfg_pulses,
   input  logic              cfg_align,
   input  logic              start,
   input  logic              stop,
   input  logic              sysref_in,
   output logic              sysref_out,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic [PCNT_W-1:0] pulse_cnt
);
   typedef enum logic [1:0] {IDLE, WAIT_ALIGN, RUN} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, p_q, h_q;
   logic [PCNT_W-1:0] n_q, pcnt_nx;
   logic sysref_in_d, pend, pend_nx, out_nx, err_nx, load;
   logic legal, rise, high, fall, last;
   assign legal = cfg_period > CNT_W'(1) && cfg_high != '0 && cfg_high < cfg_period;
   assign rise  = sysref_in & ~sysref_in_d;
   assign high  = cnt < h_q;
   assign fall  = cnt == h_q - 1'b1;
   assign last  = cnt == p_q - 1'b1;
   always_ff @(posedge pl_clk or negedge pl_resetn)
      if (!pl_resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         pend        <= 1'b0;
         sysref_in_d <= 1'b0;
         sysref_out  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
         pulse_cnt   <= '0;
         p_q         <= '0;
         h_q         <= '0;
         n_q         <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         pend        <= pend_nx;
         sysref_in_d <= sysref_in;
         sysref_out  <= out_nx;
         busy        <= state_nx != IDLE;
         done        <= state != IDLE && state_nx == IDLE;
         cfg_err     <= err_nx;
         pulse_cnt   <= pcnt_nx;
         if (load) begin
            p_q <= cfg_period;
            h_q <= cfg_high;
            n_q <= cfg_pulses;
         end
      end
   // sysref_out is registered from the next-cycle counter so it is high exactly while cnt < H
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = pend;
      pcnt_nx  = pulse_cnt;
      out_nx   = 1'b0;
      err_nx   = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE:
            if (start && !stop) begin
               if (legal) begin
                  load     = 1'b1;
                  pcnt_nx  = '0;
                  pend_nx  = 1'b0;
                  cnt_nx   = '0;
                  state_nx = cfg_align ? WAIT_ALIGN : RUN;
                  out_nx   = !cfg_align;
               end else
                  err_nx = 1'b1;
            end
         WAIT_ALIGN:
            if (stop)
               state_nx = IDLE;
            else if (rise) begin
               state_nx = RUN;
               cnt_nx   = '0;
               out_nx   = 1'b1;
            end
         RUN: begin
            if (fall && pulse_cnt != '1)
               pcnt_nx = pulse_cnt + 1'b1;
            cnt_nx  = last ? '0 : cnt + 1'b1;
            // a stop seen while high is held until the pulse's falling edge
            pend_nx = pend | stop;
            if ((fall && (stop || pend)) || (stop && !high) || (last && |n_q && pulse_cnt == n_q))
               state_nx = IDLE;
            else
               out_nx = cnt_nx < h_q;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sysref_gen.sv
// tb_sysref_gen: directed self-checking bench for sysref_gen
module tb_sysref_gen;
   localparam int CNT_W = 16, PCNT_W = 8;
   logic pl_clk = 1'b0, pl_resetn = 1'b1;
   logic [CNT_W-1:0] cfg_period = 8, cfg_high = 2;
   logic [PCNT_W-1:0] cfg_pulses = 0;
   logic cfg_align = 1'b0, start = 1'b0, stop = 1'b0, sysref_in = 1'b0;
   logic sysref_out, busy, done, cfg_err;
   logic [PCNT_W-1:0] pulse_cnt;
   int errors = 0, checks = 0;
   logic [63:0] w, ex;
   logic acc;
   int n;
   always #5 pl_clk = ~pl_clk;
   sysref_gen #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
      .pl_clk(pl_clk), .pl_resetn(pl_resetn), .cfg_period(cfg_period), .cfg_high(cfg_high),
      .cfg_pulses(cfg_pulses), .cfg_align(cfg_align), .start(start), .stop(stop),
      .sysref_in(sysref_in), .sysref_out(sysref_out), .busy(busy), .done(done),
      .cfg_err(cfg_err), .pulse_cnt(pulse_cnt)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int k = 1);
      repeat (k) @(negedge pl_clk);
   endtask
   // applies config and a one-cycle start; returns at the first cycle after the start edge
   task automatic kick(input int p, input int h, input int np, input logic a);
      cfg_period = CNT_W'(p);
      cfg_high   = CNT_W'(h);
      cfg_pulses = PCNT_W'(np);
      cfg_align  = a;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask
   task automatic wait_done(input int budget, output int k);
      k = 0;
      while (!done && k < budget) begin
         cyc();
         k++;
      end
   endtask
   task automatic err_try(input string tag, input int p, input int h);
      cfg_period = CNT_W'(p);
      cfg_high   = CNT_W'(h);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk({tag, "_err"}, cfg_err, 1);
      chk({tag, "_busy"}, busy, 0);
      cyc();
      chk({tag, "_err_off"}, cfg_err, 0);
      chk({tag, "_pcnt"}, pulse_cnt, 4);
   endtask
   initial begin
      #2 pl_resetn = 1'b0;
      cyc(2);
      chk("rst_outs", {sysref_out, busy, done, cfg_err}, 0);
      chk("rst_pcnt", pulse_cnt, 0);
      pl_resetn = 1'b1;
      cyc(9);
      // continuous P=8 H=2
      kick(8, 2, 0, 1'b0);
      chk("cont_busy", busy, 1);
      w = '0; ex = '0;
      for (int i = 0; i < 24; i++) begin
         w[i] = sysref_out;
         ex[i] = (i % 8) < 2;
         if (i % 8 == 2) chk($sformatf("cont_pcnt%0d", i), pulse_cnt, i / 8 + 1);
         cyc();
      end
      chk("cont_wave", w, ex);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("cont_stop_hold", sysref_out, 1);
      cyc();
      chk("cont_stop_end", {sysref_out, done, busy}, 3'b010);
      chk("cont_stop_pcnt", pulse_cnt, 4);
      // burst P=10 H=3 N=4, with a start and new config while busy
      kick(10, 3, 4, 1'b0);
      chk("burst_pcnt_clr", pulse_cnt, 0);
      w = '0; ex = '0;
      for (int i = 0; i < 40; i++) begin
         w[i] = sysref_out;
         ex[i] = (i % 10) < 3;
         if (i == 15) begin
            cfg_period = 4; cfg_high = 1; cfg_pulses = 1; start = 1'b1;
         end else
            start = 1'b0;
         if (i == 39) chk("burst_busy_last", {busy, done}, 2'b10);
         cyc();
      end
      chk("burst_wave", w, ex);
      chk("burst_done", {done, busy, sysref_out}, 3'b100);
      chk("burst_pcnt", pulse_cnt, 4);
      cyc();
      chk("burst_done_off", done, 0);
      chk("burst_pcnt_hold", pulse_cnt, 4);
      // illegal configs and start/stop race
      err_try("p1", 1, 1);
      err_try("h0", 8, 0);
      err_try("hp", 8, 8);
      cfg_period = 8; cfg_high = 2;
      start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      chk("race", {busy, cfg_err, sysref_out}, 0);
      cyc(3);
      chk("race_idle", {busy, sysref_out, pulse_cnt}, 4);
      // minimum legal period P=2 H=1 N=2
      kick(2, 1, 2, 1'b0);
      w = '0;
      for (int i = 0; i < 4; i++) begin
         w[i] = sysref_out;
         cyc();
      end
      chk("p2_wave", w, 64'h5);
      chk("p2_done", done, 1);
      // stop while high (cnt=2) with P=16 H=6
      kick(16, 6, 0, 1'b0);
      cyc(2);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cyc(2);
      chk("stop_hi_hold", {sysref_out, busy}, 2'b11);
      cyc();
      chk("stop_hi_end", {sysref_out, done, busy}, 3'b010);
      chk("stop_hi_pcnt", pulse_cnt, 1);
      acc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         acc |= sysref_out;
         cyc();
      end
      chk("stop_hi_quiet", {acc, done, busy}, 0);
      // stop while low (cnt=10)
      kick(16, 6, 0, 1'b0);
      cyc(10);
      chk("stop_lo_low", sysref_out, 0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("stop_lo_end", {sysref_out, done, busy}, 3'b010);
      chk("stop_lo_pcnt", pulse_cnt, 1);
      // alignment to a fresh rising edge
      kick(8, 2, 1, 1'b1);
      acc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         acc |= sysref_out;
         cyc();
      end
      chk("align_wait", {acc, busy}, 2'b01);
      sysref_in = 1'b1;
      cyc();
      chk("align_first", sysref_out, 1);
      wait_done(40, n);
      chk("align_len", n, 8);
      sysref_in = 1'b0;
      // sysref_in already high at start
      cyc(2);
      sysref_in = 1'b1;
      cyc(2);
      kick(8, 2, 1, 1'b1);
      acc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         acc |= sysref_out;
         cyc();
      end
      sysref_in = 1'b0;
      cyc(2);
      chk("align_stale", {acc, sysref_out, busy}, 3'b001);
      sysref_in = 1'b1;
      cyc();
      chk("align_fresh", sysref_out, 1);
      wait_done(40, n);
      chk("align_fresh_len", n, 8);
      sysref_in = 1'b0;
      // stop in WAIT_ALIGN
      kick(8, 2, 3, 1'b1);
      cyc(3);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("wait_stop", {done, busy, sysref_out}, 3'b100);
      chk("wait_stop_pcnt", pulse_cnt, 0);
      cyc(2);
      // async reset mid-pulse
      kick(8, 4, 0, 1'b0);
      cyc(2);
      #2 pl_resetn = 1'b0;
      #1 chk("arst_outs", {sysref_out, busy, done, cfg_err}, 0);
      chk("arst_pcnt", pulse_cnt, 0);
      cyc(2);
      pl_resetn = 1'b1;
      cyc();
      chk("arst_no_done", {done, busy, sysref_out}, 0);
      kick(8, 2, 2, 1'b0);
      chk("arst_restart", {sysref_out, busy}, 2'b11);
      wait_done(64, n);
      chk("arst_restart_len", n, 16);
      chk("arst_restart_pcnt", pulse_cnt, 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
